// File: rtl/brq_pkg.sv
// brq_pkg: shared types and constants for the branch resolve queue.
// The optional global-history checkpoint feature is enabled by defining
// BRQ_GHR_CHECKPOINT_EN; the default build has no history storage.
package brq_pkg;

    // Default width of the global history snapshot kept per branch
    localparam int BRQ_GHR_W = 12;

    // Address value meaning "no predictor update this cycle"
    localparam logic [31:0] ADDR_NONE = 32'h0;

    // One in-flight prediction (history snapshot is stored alongside when enabled)
    typedef struct packed {
        logic [31:0] addr;
        logic        pred_taken;
    } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: circular storage for in-flight branches. Head is the oldest entry,
// tail the next free slot; full/empty come from the occupancy count since the
// pointers alone cannot tell them apart. A flush discards every entry at once.
module brq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Entry payload: written at the tail, never reset (validity is tracked by occupancy)
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[tail_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else if (flush) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head_data = mem[head_ptr];
    assign full      = (occupancy == (PTR_W + 1)'(DEPTH));
    assign empty     = (occupancy == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: holds predicted conditional branches in program order
// until execute resolves them, drives the predictor update interface and the
// mispredict redirect. Define BRQ_GHR_CHECKPOINT_EN to store a global-history
// snapshot per branch and emit Repair_ghr on a mispredict.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GHR_W = BRQ_GHR_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     Flush,
    input  logic                     Pred_valid,
    input  logic [31:0]              Pred_addr,
    input  logic                     Pred_taken,
    output logic                     Pred_ready,
    input  logic                     Resolve_valid,
    input  logic [31:0]              Resolve_addr,
    input  logic                     Resolve_taken,
    output logic                     Branch_resolved,
    output logic [31:0]              Branch_resolved_addr,
    output logic                     Mispredict,
    output logic [31:0]              Mispredict_addr,
    output logic                     Resolve_error,
`ifdef BRQ_GHR_CHECKPOINT_EN
    input  logic [GHR_W-1:0]         Pred_ghr,
    output logic [GHR_W-1:0]         Repair_ghr,
`endif
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int BASE_W = $bits(brq_entry_t);
`ifdef BRQ_GHR_CHECKPOINT_EN
    localparam int GHR_STORE_W = GHR_W;
`else
    // History storage is absent in this build
    localparam int GHR_STORE_W = GHR_W * 0;
`endif
    localparam int ENTRY_W = BASE_W + GHR_STORE_W;

    brq_entry_t               new_entry;
    brq_entry_t               head_entry;
    logic [ENTRY_W-1:0]       wr_data;
    logic [ENTRY_W-1:0]       head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_flush;

    // Stage p0: compare resolve against the head and apply Flush > mispredict > normal
    logic hit_p0;
    logic addr_err_p0;
    logic mis_p0;
    logic pop_p0;
    logic push_p0;
    logic upd_p0;
    logic mis_out_p0;

    assign new_entry.addr       = Pred_addr;
    assign new_entry.pred_taken = Pred_taken;
    assign head_entry           = head_data[BASE_W-1:0];

`ifdef BRQ_GHR_CHECKPOINT_EN
    logic [GHR_W-1:0] head_ghr;
    assign wr_data  = {Pred_ghr, new_entry};
    assign head_ghr = head_data[ENTRY_W-1:BASE_W];
`else
    assign wr_data  = new_entry;
`endif

    assign hit_p0      = Resolve_valid && !fifo_empty && (Resolve_addr == head_entry.addr);
    assign addr_err_p0 = Resolve_valid && (fifo_empty || (Resolve_addr != head_entry.addr));
    assign mis_p0      = hit_p0 && (Resolve_taken != head_entry.pred_taken);
    // A mismatched resolve still retires the head, it just gives no update
    assign pop_p0      = Resolve_valid && !fifo_empty && !Flush;
    // Enqueue on a full queue is fine when the head leaves in the same cycle;
    // wrong-path enqueues behind a mispredict are discarded
    assign push_p0     = Pred_valid && (!fifo_full || pop_p0) && !Flush && !mis_p0;
    assign fifo_flush  = Flush || mis_p0;
    assign upd_p0      = hit_p0 && !Flush;
    assign mis_out_p0  = mis_p0 && !Flush;

    brq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (fifo_flush),
        .push      (push_p0),
        .pop       (pop_p0),
        .wr_data   (wr_data),
        .head_data (head_data),
        .occupancy (Occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign Pred_ready = !fifo_full;

    // Stage p1: registered predictor update, redirect pulse and sticky error
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Branch_resolved      <= 1'b0;
            Branch_resolved_addr <= ADDR_NONE;
            Mispredict           <= 1'b0;
            Mispredict_addr      <= ADDR_NONE;
            Resolve_error        <= 1'b0;
        end else begin
            Branch_resolved      <= upd_p0 ? Resolve_taken : 1'b0;
            Branch_resolved_addr <= upd_p0 ? head_entry.addr : ADDR_NONE;
            Mispredict           <= mis_out_p0;
            Mispredict_addr      <= mis_out_p0 ? head_entry.addr : ADDR_NONE;
            if (addr_err_p0) begin
                Resolve_error <= 1'b1;
            end
        end
    end

`ifdef BRQ_GHR_CHECKPOINT_EN
    // Stage p1: history repair = snapshot shifted by the actual outcome
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Repair_ghr <= '0;
        end else begin
            Repair_ghr <= mis_out_p0 ? {head_ghr[GHR_W-2:0], Resolve_taken} : '0;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and randomized stimulus against a
// queue-based reference model; expected outputs go to a scoreboard that a
// separate monitor drains on the falling clock edge.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int GHR_W = 12;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               Flush = 1'b0;
    logic               Pred_valid = 1'b0;
    logic [31:0]        Pred_addr = 32'h0;
    logic               Pred_taken = 1'b0;
    logic               Pred_ready;
    logic               Resolve_valid = 1'b0;
    logic [31:0]        Resolve_addr = 32'h0;
    logic               Resolve_taken = 1'b0;
    logic               Branch_resolved;
    logic [31:0]        Branch_resolved_addr;
    logic               Mispredict;
    logic [31:0]        Mispredict_addr;
    logic               Resolve_error;
    logic [OCC_W-1:0]   Occupancy;
`ifdef BRQ_GHR_CHECKPOINT_EN
    logic [GHR_W-1:0]   Pred_ghr = '0;
    logic [GHR_W-1:0]   Repair_ghr;
`endif

    branch_resolve_queue #(
        .DEPTH (DEPTH),
        .GHR_W (GHR_W)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Flush                (Flush),
        .Pred_valid           (Pred_valid),
        .Pred_addr            (Pred_addr),
        .Pred_taken           (Pred_taken),
        .Pred_ready           (Pred_ready),
        .Resolve_valid        (Resolve_valid),
        .Resolve_addr         (Resolve_addr),
        .Resolve_taken        (Resolve_taken),
        .Branch_resolved      (Branch_resolved),
        .Branch_resolved_addr (Branch_resolved_addr),
        .Mispredict           (Mispredict),
        .Mispredict_addr      (Mispredict_addr),
        .Resolve_error        (Resolve_error),
`ifdef BRQ_GHR_CHECKPOINT_EN
        .Pred_ghr             (Pred_ghr),
        .Repair_ghr           (Repair_ghr),
`endif
        .Occupancy            (Occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]      addr;
        logic             taken;
        logic [GHR_W-1:0] ghr;
    } ent_t;

    typedef struct {
        logic [31:0]      bra;
        logic             br;
        logic             mis;
        logic [31:0]      misa;
        logic [GHR_W-1:0] rep;
        logic             err;
        int               occ;
        logic             rdy;
    } exp_t;

    ent_t model_q[$];
    bit   model_err;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every registered output set announced by the driver is checked here
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("Branch_resolved_addr", Branch_resolved_addr, e.bra);
            chk("Branch_resolved", 32'(Branch_resolved), 32'(e.br));
            chk("Mispredict", 32'(Mispredict), 32'(e.mis));
            if (e.mis) chk("Mispredict_addr", Mispredict_addr, e.misa);
            chk("Resolve_error", 32'(Resolve_error), 32'(e.err));
            chk("Occupancy", 32'(Occupancy), 32'(e.occ));
            chk("Pred_ready", 32'(Pred_ready), 32'(e.rdy));
`ifdef BRQ_GHR_CHECKPOINT_EN
            chk("Repair_ghr", 32'(Repair_ghr), 32'(e.rep));
`endif
        end
    end

    // Reference model: one clock edge of queue behaviour from the rules in words
    task automatic model_edge(input bit fl, input bit pv, input logic [31:0] pa, input bit pt,
                              input logic [GHR_W-1:0] pg, input bit rv, input logic [31:0] ra,
                              input bit rt, output exp_t e);
        ent_t h;
        ent_t n;
        bit   was_full;
        bit   popped;
        bit   mp;
        e.bra = 32'h0; e.br = 1'b0; e.mis = 1'b0; e.misa = 32'h0; e.rep = '0;
        was_full = (model_q.size() == DEPTH);
        popped = 1'b0;
        mp = 1'b0;
        if (rv && (model_q.size() == 0 || model_q[0].addr != ra)) model_err = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (rv && model_q.size() > 0) begin
                h = model_q.pop_front();
                popped = 1'b1;
                if (h.addr == ra) begin
                    e.bra = ra;
                    e.br  = rt;
                    if (rt != h.taken) begin
                        mp = 1'b1;
                        e.mis = 1'b1;
                        e.misa = ra;
                        e.rep = {h.ghr[GHR_W-2:0], rt};
                        model_q.delete();
                    end
                end
            end
            if (pv && !mp && (!was_full || popped)) begin
                n.addr = pa; n.taken = pt; n.ghr = pg;
                model_q.push_back(n);
            end
        end
        e.err = model_err;
        e.occ = model_q.size();
        e.rdy = (model_q.size() < DEPTH);
    endtask

    task automatic step(input bit fl, input bit pv, input logic [31:0] pa, input bit pt,
                        input logic [GHR_W-1:0] pg, input bit rv, input logic [31:0] ra,
                        input bit rt);
        exp_t e;
        @(negedge CLK);
        Flush = fl; Pred_valid = pv; Pred_addr = pa; Pred_taken = pt;
        Resolve_valid = rv; Resolve_addr = ra; Resolve_taken = rt;
`ifdef BRQ_GHR_CHECKPOINT_EN
        Pred_ghr = pg;
`endif
        model_edge(fl, pv, pa, pt, pg, rv, ra, rt, e);
        @(posedge CLK);
        #1;
        exp_q.push_back(e);
        Flush = 1'b0; Pred_valid = 1'b0; Resolve_valid = 1'b0;
    endtask

    task automatic enq(input logic [31:0] a, input bit t);
        step(1'b0, 1'b1, a, t, 12'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic res(input logic [31:0] a, input bit t);
        step(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b1, a, t);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge CLK);
        RESET = 1'b0;
        Flush = 1'b0; Pred_valid = 1'b0; Resolve_valid = 1'b0;
        model_q.delete();
        model_err = 1'b0;
        #1;
        e.bra = 32'h0; e.br = 1'b0; e.mis = 1'b0; e.misa = 32'h0; e.rep = '0;
        e.err = 1'b0; e.occ = 0; e.rdy = 1'b1;
        exp_q.push_back(e);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        bit          rt;
        bit          rv;
        do_reset();

        // Correct prediction, enqueue then resolve on the next edge
        enq(32'h0040_0010, 1'b1);
        res(32'h0040_0010, 1'b1);
        idle();

        // Mispredict discards younger entries; later resolve hits an empty queue
        enq(32'h100, 1'b0);
        enq(32'h104, 1'b1);
        enq(32'h108, 1'b1);
        res(32'h100, 1'b1);
        idle();
        res(32'h104, 1'b1);

        // Full queue: dropped enqueue, then enqueue + correct resolve at full
        do_reset();
        for (int i = 0; i < DEPTH; i++) enq(32'h500 + 32'(4 * i), 1'b1);
        enq(32'h600, 1'b1);
        step(1'b0, 1'b1, 32'h604, 1'b1, 12'h0, 1'b1, 32'h500, 1'b1);
        idle();

        // Address mismatch pops the head without an update
        do_reset();
        enq(32'h204, 1'b1);
        res(32'h200, 1'b1);
        idle();

        // Flush with a coincident resolve and enqueue
        do_reset();
        for (int i = 0; i < 5; i++) enq(32'h700 + 32'(4 * i), 1'b0);
        step(1'b1, 1'b1, 32'h800, 1'b0, 12'h0, 1'b1, 32'h700, 1'b1);
        idle();

        // History repair on a taken mispredict
        do_reset();
        step(1'b0, 1'b1, 32'h300, 1'b0, 12'hABC, 1'b0, 32'h0, 1'b0);
        res(32'h300, 1'b1);
        idle();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            rv = ($urandom_range(0, 2) == 0);
            if (model_q.size() > 0 && $urandom_range(0, 7) != 0) begin
                ra = model_q[0].addr;
                rt = ($urandom_range(0, 4) == 0) ? !model_q[0].taken : model_q[0].taken;
            end else begin
                ra = 32'h1000 + 32'(4 * $urandom_range(0, 63));
                rt = 1'($urandom);
            end
            step(($urandom_range(0, 49) == 0), 1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 63)),
                 1'($urandom), 12'($urandom), rv, ra, rt);
        end

        idle();
        @(negedge CLK);
        @(negedge CLK);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
